// File: rtl/dot_sched_pkg.sv
// Shared constants and the FSM state type of the dot-product scheduler.
package dot_sched_pkg;

    localparam int DATA_WIDTH = 8;
    localparam int VEC_LENGTH = 3;
    localparam int ACC_W      = 2*DATA_WIDTH + $clog2(VEC_LENGTH);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOAD_A = 2'd1,
        LOAD_B = 2'd2,
        DONE   = 2'd3
    } dot_sched_state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first requesting index at or after ptr.
module rr_arbiter #(
    parameter int NUM_REQ = 4
) (
    input  logic [NUM_REQ-1:0]         req,
    input  logic [$clog2(NUM_REQ)-1:0] ptr,
    output logic                       gnt_valid,
    output logic [$clog2(NUM_REQ)-1:0] gnt_idx
);
    import dot_sched_pkg::*;

    localparam int ID_W = $clog2(NUM_REQ);

    // Scan from the farthest offset down so the nearest requester wins last.
    always_comb begin
        int j;
        gnt_valid = 1'b0;
        gnt_idx   = ptr;
        for (int i = NUM_REQ-1; i >= 0; i--) begin
            j = int'(ptr) + i;
            if (j >= NUM_REQ) j = j - NUM_REQ;
            if (req[ID_W'(j)]) begin
                gnt_valid = 1'b1;
                gnt_idx   = ID_W'(j);
            end
        end
    end

endmodule

// File: rtl/dot_product_sched.sv
// Round-robin scheduler sharing one unsigned dot-product MAC among NUM_REQ requesters.
// Optional stall timeout is built in when DOT_SCHED_TIMEOUT_EN is defined.
module dot_product_sched #(
    parameter int NUM_REQ     = 4,
    parameter int DATA_WIDTH  = dot_sched_pkg::DATA_WIDTH,
    parameter int VEC_LENGTH  = dot_sched_pkg::VEC_LENGTH,
    parameter int ACC_W       = 2*DATA_WIDTH + $clog2(VEC_LENGTH),
    parameter int TIMEOUT_CYC = 16
) (
    input  logic                          clk,
    input  logic                          resetn,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_din,
    output logic [NUM_REQ-1:0]            req_ready,
    output logic                          res_valid,
    input  logic                          res_ready,
    output logic [ACC_W-1:0]              res_data,
    output logic [$clog2(NUM_REQ)-1:0]    res_id,
    output logic                          res_err,
    output logic                          busy,
    output logic [1:0]                    dbg_state
);
    import dot_sched_pkg::*;

    // Handshakes: a beat moves when req_valid[i] && req_ready[i] at a rising clk;
    // a result moves when res_valid && res_ready. Valid never waits on ready.

    localparam int ID_W   = $clog2(NUM_REQ);
    localparam int IDX_W  = (VEC_LENGTH > 1) ? $clog2(VEC_LENGTH) : 1;
    localparam int PROD_W = 2*DATA_WIDTH;

    dot_sched_state_t      state;
    logic [ID_W-1:0]       gnt_id;
    logic [ID_W-1:0]       ptr;
    logic [ID_W-1:0]       ptr_next;
    logic [ID_W-1:0]       arb_idx;
    logic                  arb_valid;
    logic [IDX_W-1:0]      idx;
    logic [DATA_WIDTH-1:0] a_mem [VEC_LENGTH];
    logic [ACC_W-1:0]      acc;
    logic [ACC_W-1:0]      acc_next;
    logic [PROD_W-1:0]     prod;
    logic [DATA_WIDTH-1:0] din_sel;
    logic                  beat;
    logic                  last_idx;
    logic                  stall_hit;

    rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
        .req       (req_valid),
        .ptr       (ptr),
        .gnt_valid (arb_valid),
        .gnt_idx   (arb_idx)
    );

    assign ptr_next  = (arb_idx == ID_W'(NUM_REQ-1)) ? '0 : arb_idx + 1'b1;
    assign din_sel   = req_din[int'(gnt_id)*DATA_WIDTH +: DATA_WIDTH];
    assign beat      = req_valid[gnt_id] & req_ready[gnt_id];
    assign last_idx  = (idx == IDX_W'(VEC_LENGTH-1));
    assign prod      = a_mem[idx] * din_sel;
    assign acc_next  = acc + ACC_W'(prod);
    assign busy      = (state != IDLE);
    assign dbg_state = state;

`ifdef DOT_SCHED_TIMEOUT_EN
    localparam int STALL_W = $clog2(TIMEOUT_CYC+1);
    logic [STALL_W-1:0] stall_cnt;

    assign stall_hit = ((state == LOAD_A) || (state == LOAD_B)) && !req_valid[gnt_id]
                       && (stall_cnt == STALL_W'(TIMEOUT_CYC-1));

    always_ff @(posedge clk) begin
        if (!resetn || (state == IDLE) || (state == DONE) || beat)
            stall_cnt <= '0;
        else if (!req_valid[gnt_id])
            stall_cnt <= stall_cnt + 1'b1;
    end
`else
    // Without the timeout a stalled requester simply keeps the MAC.
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = (TIMEOUT_CYC != 0);
    assign stall_hit = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state     <= IDLE;
            gnt_id    <= '0;
            ptr       <= '0;
            idx       <= '0;
            acc       <= '0;
            req_ready <= '0;
            res_valid <= 1'b0;
            res_data  <= '0;
            res_id    <= '0;
            res_err   <= 1'b0;
            for (int i = 0; i < VEC_LENGTH; i++) a_mem[i] <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (arb_valid) begin
                        gnt_id    <= arb_idx;
                        ptr       <= ptr_next;
                        idx       <= '0;
                        req_ready <= NUM_REQ'(1) << arb_idx;
                        state     <= LOAD_A;
                    end
                end
                LOAD_A: begin
                    if (stall_hit) begin
                        req_ready <= '0;
                        res_valid <= 1'b1;
                        res_data  <= '0;
                        res_id    <= gnt_id;
                        res_err   <= 1'b1;
                        state     <= DONE;
                    end else if (beat) begin
                        a_mem[idx] <= din_sel;
                        if (last_idx) begin
                            idx   <= '0;
                            acc   <= '0;
                            state <= LOAD_B;
                        end else begin
                            idx <= idx + 1'b1;
                        end
                    end
                end
                LOAD_B: begin
                    if (stall_hit) begin
                        req_ready <= '0;
                        res_valid <= 1'b1;
                        res_data  <= '0;
                        res_id    <= gnt_id;
                        res_err   <= 1'b1;
                        state     <= DONE;
                    end else if (beat) begin
                        if (last_idx) begin
                            req_ready <= '0;
                            res_valid <= 1'b1;
                            res_data  <= acc_next;
                            res_id    <= gnt_id;
                            res_err   <= 1'b0;
                            idx       <= '0;
                            state     <= DONE;
                        end else begin
                            acc <= acc_next;
                            idx <= idx + 1'b1;
                        end
                    end
                end
                DONE: begin
                    // Result registers keep their value after the handshake.
                    if (res_ready) begin
                        res_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
